// File: rtl/mem_if_pkg.sv
// Shared types and constants for the line-transfer memory interface.
package mem_if_pkg;

  localparam int WORD_W        = 32;
  localparam int ADDR_W        = 64;
  localparam int LINE_WORDS    = 16;
  localparam int LINE_OFS_BITS = 6;
  localparam int BEAT_W        = 4;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b11
  } mem_op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_LAT,
    RD_BURST,
    WR_BURST,
    DONE
  } resp_state_e;

endpackage

// File: rtl/mem_line_store.sv
// Line-organised backing store: one synchronous write port, one
// combinational read port, both addressed by (line, word). Not reset.
module mem_line_store
  import mem_if_pkg::*;
#(
  parameter int DEPTH_LINES = 64,
  localparam int IDX_W = $clog2(DEPTH_LINES)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_line,
  input  logic [BEAT_W-1:0] wr_word,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_line,
  input  logic [BEAT_W-1:0] rd_word,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH_LINES*LINE_WORDS];

  // Single write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_line, wr_word}] <= wr_data;
  end

  assign rd_data = mem[{rd_line, rd_word}];

endmodule

// File: rtl/mem_line_responder.sv
// Responder end of the line-transfer interface: accepts READ/WRITE line
// requests, streams 16-word reads and captures 16-word writes.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for op; the only state where op is sampled
// RD_LAT   | read latency countdown before the first beat
// RD_BURST | 16 read beats, data driven from the registered beat
// WR_BURST | optional wait cycles, then 16 captured write beats
// DONE     | one turnaround cycle, busy only
module mem_line_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_LINES = 64,
  parameter int RD_LATENCY  = 2,
  parameter int WR_WAIT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  op,
  input  logic [63:0] io_address,
  input  logic [31:0] common_data_bus_in,
  output logic [31:0] common_data_bus_out,
  output logic        rd_valid,
  output logic        tx_done,
  output logic        busy
);

  localparam int IDX_W   = $clog2(DEPTH_LINES);
  localparam int CNT_MAX = (RD_LATENCY > WR_WAIT) ? RD_LATENCY : WR_WAIT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  resp_state_e       state;
  logic [BEAT_W-1:0] beat;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  line;
  logic [IDX_W-1:0]  req_line;
  logic              wr_active;
  logic              last_beat;
  logic              wr_en;
  logic [WORD_W-1:0] rd_word;
  logic              unused_addr_bits;

  // Only the line-index bits of the address matter; the rest alias.
  assign req_line         = io_address[LINE_OFS_BITS +: IDX_W];
  assign unused_addr_bits = ^{io_address[ADDR_W-1:LINE_OFS_BITS+IDX_W],
                              io_address[LINE_OFS_BITS-1:0]};

  assign wr_active = (state == WR_BURST) && (cnt == '0);
  assign last_beat = (beat == 4'hF);
  // A reset edge during a write burst must not commit the current word.
  assign wr_en     = wr_active && !rst;

  // Request sequencing, latency/wait countdown and beat tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      cnt   <= '0;
      line  <= '0;
    end else begin
      case (state)
        IDLE: begin
          case (mem_op_e'(op))
            MEM_READ: begin
              line <= req_line;
              beat <= '0;
              if (RD_LATENCY == 0) begin
                state <= RD_BURST;
                cnt   <= '0;
              end else begin
                state <= RD_LAT;
                cnt   <= CNT_W'(RD_LATENCY);
              end
            end
            MEM_WRITE: begin
              line  <= req_line;
              beat  <= '0;
              cnt   <= CNT_W'(WR_WAIT);
              state <= WR_BURST;
            end
            default: ;
          endcase
        end
        RD_LAT: begin
          if (cnt == CNT_W'(1)) begin
            state <= RD_BURST;
            cnt   <= '0;
            beat  <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RD_BURST: begin
          beat <= beat + 4'd1;
          if (last_beat) state <= DONE;
        end
        WR_BURST: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            beat <= beat + 4'd1;
            if (last_beat) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mem_line_store #(
    .DEPTH_LINES(DEPTH_LINES)
  ) u_store (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_line(line),
    .wr_word(beat),
    .wr_data(common_data_bus_in),
    .rd_line(line),
    .rd_word(beat),
    .rd_data(rd_word)
  );

  assign rd_valid            = (state == RD_BURST);
  assign tx_done             = last_beat && (rd_valid || wr_active);
  assign busy                = (state != IDLE);
  assign common_data_bus_out = rd_valid ? rd_word : '0;

endmodule
